// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes and
// arbiter FSM state encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_unit.sv
// Combinational ALU: decodes the control code and computes the result.
// Unsupported codes yield result 0 with err set.
module alu_op_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  // Operation decode and compute; carry/borrow naturally dropped by width.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ctrl)
      CTRL_W'(ALU_AND): result = a & b;
      CTRL_W'(ALU_OR):  result = a | b;
      CTRL_W'(ALU_ADD): result = a + b;
      CTRL_W'(ALU_SUB): result = a - b;
      CTRL_W'(ALU_SLT): result = DATA_W'($signed(a) < $signed(b));
      CTRL_W'(ALU_NOR): result = ~(a | b);
      default:          err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU.
// Flow: IDLE (grant + capture) -> EXEC (register result) -> RESP (hold until
// the granted requester consumes it).
// Optional feature: define ALU_ARBITER_ZERO_FLAG_EN to add the rsp_zero output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  ,
  output logic              rsp_zero
`endif
);

  state_e            state;
  state_e            state_nxt;
  logic              ptr;
  logic              grant;
  logic              pick;
  logic              take;
  logic              consumed;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [CTRL_W-1:0] op_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;

  alu_op_unit #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_op (
    .a      (op_a),
    .b      (op_b),
    .ctrl   (op_ctrl),
    .result (alu_result),
    .err    (alu_err)
  );

  // Grant selection, handshake outputs and next-state logic.
  always_comb begin
    // With both valid the pointer decides; otherwise the lone requester wins.
    pick       = (req0_valid && req1_valid) ? ptr : req1_valid;
    take       = (state == IDLE) && !reset && (req0_valid || req1_valid);
    req0_ready = take && !pick;
    req1_ready = take && pick;
    rsp0_valid = (state == RESP) && !grant;
    rsp1_valid = (state == RESP) && grant;
    consumed   = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);
    state_nxt  = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (consumed) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture and granted-requester record on the accept cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= '0;
      grant   <= 1'b0;
    end else if (take) begin
      op_a    <= pick ? req1_a    : req0_a;
      op_b    <= pick ? req1_b    : req0_b;
      op_ctrl <= pick ? req1_ctrl : req0_ctrl;
      grant   <= pick;
    end
  end

  // Result registers loaded in EXEC and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= alu_result;
      rsp_err    <= alu_err;
    end
  end

  // Round-robin pointer moves to the other requester once a response is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ptr <= 1'b0;
    else if (consumed) ptr <= ~grant;
  end

`ifdef ALU_ARBITER_ZERO_FLAG_EN
  // Zero flag registered alongside the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rsp_zero <= 1'b0;
    else if (state == EXEC) rsp_zero <= (alu_result == '0);
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter (DATA_W=32, CTRL_W=4).
module tb_alu_arbiter;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  exp_t        sb[$];
  logic [31:0] pa[2];
  logic [31:0] pb[2];
  logic [3:0]  pc[2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_grant = 0;

  alu_arbiter #(
    .DATA_W(32),
    .CTRL_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    ,
    .rsp_zero   (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int id, input logic [3:0] c,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id     = id;
    e.result = 32'd0;
    e.err    = 1'b0;
    case (c)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: e.result = a + b;
      4'b0110: e.result = a - b;
      4'b0111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.result = ~(a | b);
      default: e.err    = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    pa[n] = a;
    pb[n] = b;
    pc[n] = c;
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  // Called mid-cycle in IDLE: checks which requester is granted, records the
  // expected result, then steps past the accept edge.
  task automatic grant(input int n);
    #0;
    check($sformatf("grant%0d_ready", n), {30'd0, req1_ready, req0_ready},
          (n == 0) ? 32'd1 : 32'd2);
    sb.push_back(model(n, pc[n], pa[n], pb[n]));
    t_grant = cyc;
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    check("exec_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  // Waits (bounded) for the response, checks latency, holds rspN_ready low for
  // 'hold' cycles checking stability, then consumes and compares.
  task automatic collect(input int n, input int hold);
    exp_t e;
    logic v;
    int   waited;
    v = 1'b0;
    waited = 0;
    while (!v && waited < 10) begin
      step();
      waited++;
      v = (n == 0) ? rsp0_valid : rsp1_valid;
    end
    check($sformatf("rsp%0d_latency", n), cyc - t_grant, 32'd2);
    check($sformatf("rsp%0d_other_valid", n), {31'd0, (n == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, (n == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
      check("hold_result", rsp_result, e.result);
      check("hold_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
    end
    if (n == 0) rsp0_ready = 1'b1;
    else        rsp1_ready = 1'b1;
    #1;
    check($sformatf("rsp%0d_result", n), rsp_result, e.result);
    check($sformatf("rsp%0d_err", n), {31'd0, rsp_err}, {31'd0, e.err});
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    check($sformatf("rsp%0d_zero", n), {31'd0, rsp_zero}, {31'd0, (e.result == 32'd0)});
`endif
    check("consume_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk);
    #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("post_consume_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) step();

    // Reset state with both requesters presenting work.
    drive(0, 4'b0110, 32'h0000000A, 32'h0000000B);
    drive(1, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    #1;
    check("rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);

    // Both valid right after reset release: req0 first, then req1.
    reset = 1'b0;
    grant(0);
    collect(0, 0);
    step();
    grant(1);
    collect(1, 0);

    // req0 ADD 5+3.
    step();
    drive(0, 4'b0010, 32'h00000005, 32'h00000003);
    grant(0);
    collect(0, 0);

    // req1 SLT -1 < 1; req0 NOR 0,0.
    step();
    drive(1, 4'b0111, 32'hFFFFFFFF, 32'h00000001);
    grant(1);
    collect(1, 0);
    step();
    drive(0, 4'b1100, 32'h00000000, 32'h00000000);
    grant(0);
    collect(0, 0);

    // Backpressure: req0 result held 5 cycles while req1 waits.
    step();
    drive(0, 4'b0001, 32'h12340000, 32'h00005678);
    grant(0);
    drive(1, 4'b0110, 32'h00000000, 32'h00000001);
    collect(0, 5);
    step();
    grant(1);
    collect(1, 0);

    // Unsupported code on req0 (leaves pointer at 1).
    step();
    drive(0, 4'b0101, 32'h12345678, 32'h9ABCDEF0);
    grant(0);
    collect(0, 0);

    // Reset in EXEC discards the operation and clears the pointer.
    step();
    drive(0, 4'b0010, 32'h00000001, 32'h00000001);
    grant(0);
    reset = 1'b1;
    #1;
    check("exec_rst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("exec_rst_result", rsp_result, 32'd0);
    sb.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    drive(1, 4'b0000, 32'hFFFF0000, 32'h0F0F0F0F);
    drive(0, 4'b0010, 32'hFFFFFFFF, 32'h00000002);
    grant(0);
    collect(0, 0);
    step();
    grant(1);
    collect(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have, for N = 0 and 1, port reqN_valid  input  1  requester N presents an operation.
REQ-006 SHALL have, for N = 0 and 1, port reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-007 SHALL have, for N = 0 and 1, port reqN_a  input  DATA_W  first operand (Read_data1 role).
REQ-008 SHALL have, for N = 0 and 1, port reqN_b  input  DATA_W  second operand (Read_data2 role).
REQ-009 SHALL have, for N = 0 and 1, port reqN_ctrl  input  CTRL_W  ALU control code.
REQ-010 SHALL have, for N = 0 and 1, port rspN_valid  output  1  result for requester N held.
REQ-011 SHALL have, for N = 0 and 1, port rspN_ready  input  1  requester N consumes the result.
REQ-012 SHALL have port rsp_result  output  DATA_W  result, shared by both response channels.
REQ-013 SHALL have port rsp_err  output  1  unsupported control code flag.

Function
REQ-014 SHALL decode codes 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-015 SHALL compute ADD/SUB modulo 2^DATA_W, with carry/borrow discarded.
REQ-016 SHALL compute SLT as a signed two's-complement compare: 1 if a<b, else 0, zero-extended.
REQ-017 SHALL return result 0 with rsp_err=1 for any other code; rsp_err SHALL be 0 for all supported codes.
REQ-018 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-019 SHALL, in IDLE with at least one reqN_valid, grant one requester and assert that reqN_ready combinationally in the same cycle.
REQ-020 SHALL, on the grant cycle, capture that requester's a/b/ctrl and go to EXEC.
REQ-021 SHALL hold both reqN_ready at 0 outside IDLE.
REQ-022 SHALL, when both are valid, grant the requester indicated by the round-robin pointer (reset value 0).
REQ-023 SHALL, when only one is valid, grant it regardless of the pointer.
REQ-024 SHALL, in EXEC, register rsp_result/rsp_err from the captured operands and go to RESP.
REQ-025 SHALL, in RESP, assert only the granted rspN_valid, holding rsp_result and rsp_err stable until that rspN_ready is high.
REQ-026 SHALL, on RESP with rspN_ready=1, return to IDLE and set the pointer to the other requester.
REQ-027 SHALL ignore the non-granted rspN_ready.
REQ-028 SHALL meet latency: accept at cycle T gives rspN_valid at T+2; best-case throughput is one operation per 3 cycles.
REQ-029 SHALL not accept a new request in the cycle a response is consumed; acceptance resumes in the next IDLE cycle.
REQ-030 SHALL treat input changes while not granted as don't-care.

Reset
REQ-031 SHALL, on reset asserted at any time, force IDLE, pointer 0, all reqN_ready and rspN_valid 0, and rsp_result and rsp_err 0.
REQ-032 SHALL discard any in-flight operation or pending response on reset, with no response issued after reset release.
REQ-033 SHALL allow grants in the first clock edge after reset deasserts.

Configuration
REQ-034 SHALL, with macro ALU_ARBITER_ZERO_FLAG_EN defined, add output rsp_zero (1 bit), registered with rsp_result, =1 iff the result equals 0, reset value 0.
REQ-035 SHALL, without ALU_ARBITER_ZERO_FLAG_EN, omit port rsp_zero and its logic entirely.

Structure
REQ-036 SHALL place the control-code constants (AND, OR, ADD, SUB, SLT, NOR) and the FSM state encodings in shared package alu_pkg.
REQ-037 SHALL implement the combinational operation decode/compute as sub-module alu_op_unit (inputs a, b, ctrl; outputs result, err); the arbiter SHALL contain only FSM, pointer and registers.

Verification
REQ-038 SHALL cover: req0 ADD a=0x00000005 b=0x00000003 -> req0_ready at T, rsp0_valid at T+2, result 0x00000008, err 0.
REQ-039 SHALL cover: both valid after reset, req0 SUB 0x0000000A-0x0000000B, req1 AND 0xF0F0F0F0&0xFF00FF00 -> req0 served first with 0xFFFFFFFF, then req1 with 0xF000F000.
REQ-040 SHALL cover: req1 SLT a=0xFFFFFFFF b=0x00000001 -> result 0x00000001; NOR 0 with 0 -> 0xFFFFFFFF.
REQ-041 SHALL cover: ctrl=0101 -> result 0, rsp_err 1; with macro defined, rsp_zero 1.
REQ-042 SHALL cover: rsp0_ready held low for 5 cycles -> rsp0_valid and result stable, both reqN_ready 0, req1 not granted until after consumption.
REQ-043 SHALL cover: reset pulsed during EXEC -> no rspN_valid ever asserts for that operation; the next request is granted per pointer 0.
